cpu_fetch: RTL and testbench

Instruction fetch stage of the CPU. Holds the program counter and issues one instruction-memory read at a time over a valid/ready request channel. Presents each returned instruction with its PC to decode over a valid/ready channel. Takes PC redirects from execute, qualified by the `branch` decision of the branch-condition unit, and drops any fetch made on the wrong path.

---
 rtl/cpu_fetch.sv | 88 ++++++++
 tb/tb_cpu_fetch.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_fetch.sv
// cpu_fetch: instruction fetch stage, one outstanding memory read, registered
// instruction buffer towards decode, and redirect handling with wrong-path drop.
module cpu_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [15:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [15:0] mem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [15:0] inst_data,
    output logic [15:0] inst_pc,
    input  logic        redirect_valid,
    input  logic        branch,
    input  logic [15:0] redirect_target
);
    typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;
    state_t state_q, state_d;
    logic [15:0] pc_q, pc_d, req_pc_q, req_pc_d, data_q, data_d, ipc_q, ipc_d;
    logic discard_q, discard_d, take, drop;
    assign take = redirect_valid && branch;
    assign drop = discard_q || take;
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        data_d    = data_q;
        ipc_d     = ipc_q;
        discard_d = discard_q;
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                pc_d    = take ? redirect_target : pc_q;
            end
            FETCH: begin
                // a redirect overrides the increment, and a request accepted alongside it is wrong-path
                pc_d = take ? redirect_target : mem_req_ready ? pc_q + 16'd1 : pc_q;
                if (mem_req_ready) begin
                    req_pc_d  = pc_q;
                    discard_d = take;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                pc_d = take ? redirect_target : pc_q;
                if (mem_resp_valid) begin
                    discard_d = 1'b0;
                    state_d   = drop ? FETCH : HOLD;
                    data_d    = drop ? data_q : mem_resp_data;
                    ipc_d     = drop ? ipc_q : req_pc_q;
                end else if (take) begin
                    discard_d = 1'b1;
                end
            end
            HOLD: begin
                pc_d    = take ? redirect_target : pc_q;
                state_d = (take || inst_ready) ? FETCH : HOLD;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            req_pc_q  <= RESET_PC;
            data_q    <= 16'h0000;
            ipc_q     <= 16'h0000;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_pc_q  <= req_pc_d;
            data_q    <= data_d;
            ipc_q     <= ipc_d;
            discard_q <= discard_d;
        end
    end
    assign mem_req_valid = state_q == FETCH;
    assign mem_req_addr  = pc_q;
    assign inst_valid    = state_q == HOLD;
    assign inst_data     = data_q;
    assign inst_pc       = ipc_q;
endmodule

// File: tb/tb_cpu_fetch.sv
// tb_cpu_fetch: directed and randomized checks of cpu_fetch against a transaction-level model
// of the instruction stream (expected fetch address, outstanding fetch, presented instruction).
module tb_cpu_fetch;
    logic        clock = 1'b0, reset = 1'b0;
    logic        mem_req_valid, mem_req_ready = 1'b0;
    logic [15:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [15:0] mem_resp_data = 16'h0;
    logic        inst_valid, inst_ready = 1'b0;
    logic [15:0] inst_data, inst_pc;
    logic        redirect_valid = 1'b0, branch = 1'b0;
    logic [15:0] redirect_target = 16'h0;
    logic        w_req_valid, w_resp_valid, w_inst_valid;
    logic [15:0] w_req_addr, w_resp_data, w_inst_data, w_inst_pc;
    int checks = 0, errors = 0;
    int rdy_pct, irdy_pct, rv_pct, br_pct, dly_min, dly_max;
    bit tgt_rand;
    logic [15:0] tgt_fix, hp, hd;
    bit m_pend;
    int m_cnt;
    logic [15:0] m_addr;
    logic [15:0] exp_pc, exp_ipc, out_a;
    bit out_v, out_stale, exp_iv, in_idle;

    always #5 clock = ~clock;

    cpu_fetch #(.RESET_PC(16'h0100)) u_dut (
        .clock(clock), .reset(reset),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .branch(branch), .redirect_target(redirect_target)
    );

    cpu_fetch #(.RESET_PC(16'hFFFF)) u_wrap (
        .clock(clock), .reset(reset),
        .mem_req_valid(w_req_valid), .mem_req_ready(1'b1), .mem_req_addr(w_req_addr),
        .mem_resp_valid(w_resp_valid), .mem_resp_data(w_resp_data),
        .inst_valid(w_inst_valid), .inst_ready(1'b1), .inst_data(w_inst_data), .inst_pc(w_inst_pc),
        .redirect_valid(1'b0), .branch(1'b0), .redirect_target(16'h0000)
    );

    // zero-wait memory for the wrap instance
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            w_resp_valid <= 1'b0;
            w_resp_data  <= 16'h0;
        end else begin
            w_resp_valid <= w_req_valid;
            w_resp_data  <= w_req_addr ^ 16'hA5A5;
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic check_state();
        bit idle_ok;
        idle_ok = !(exp_iv || out_v || in_idle);
        chk("inst_valid", 16'(inst_valid), 16'(exp_iv));
        if (exp_iv) begin
            chk("inst_pc", inst_pc, exp_ipc);
            chk("inst_data", inst_data, exp_ipc ^ 16'hA5A5);
        end
        chk("req_valid", 16'(mem_req_valid), 16'(idle_ok));
        if (idle_ok) chk("req_addr_pre", mem_req_addr, exp_pc);
    endtask

    // one clock: drive at negedge, update memory and model at posedge, compare at next negedge
    task automatic cycle();
        bit req_hs, rv, tk, ihs;
        logic [15:0] req_a;
        mem_req_ready = m_pend ? 1'b0 : 1'($urandom_range(99) < rdy_pct);
        mem_resp_valid = m_pend && m_cnt == 0;
        mem_resp_data = mem_resp_valid ? (m_addr ^ 16'hA5A5) : 16'($urandom);
        inst_ready = 1'($urandom_range(99) < irdy_pct);
        redirect_valid = 1'($urandom_range(99) < rv_pct);
        branch = 1'($urandom_range(99) < br_pct);
        redirect_target = tgt_rand ? 16'($urandom) : tgt_fix;
        req_hs = mem_req_valid && mem_req_ready;
        req_a = mem_req_addr;
        rv = mem_resp_valid;
        tk = redirect_valid && branch;
        ihs = inst_valid && inst_ready;
        @(posedge clock);
        if (rv) m_pend = 0;
        else if (m_pend) m_cnt--;
        if (req_hs) begin
            m_pend = 1;
            m_addr = req_a;
            m_cnt = int'($urandom_range(dly_max, dly_min));
        end
        in_idle = 0;
        if (exp_iv && (ihs || tk)) exp_iv = 0;
        if (req_hs) begin
            chk("req_addr", req_a, exp_pc);
            out_v = 1;
            out_a = req_a;
            out_stale = tk;
            exp_pc = req_a + 16'd1;
        end else if (rv && out_v) begin
            if (!out_stale && !tk) begin
                exp_iv = 1;
                exp_ipc = out_a;
            end
            out_v = 0;
        end
        if (tk) begin
            exp_pc = redirect_target;
            if (out_v) out_stale = 1;
        end
        @(negedge clock);
        check_state();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        branch = 1'b0;
        #1;
        chk("rst_req_valid", 16'(mem_req_valid), 16'h0);
        chk("rst_req_addr", mem_req_addr, 16'h0100);
        chk("rst_inst_valid", 16'(inst_valid), 16'h0);
        chk("rst_inst_data", inst_data, 16'h0);
        chk("rst_inst_pc", inst_pc, 16'h0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        exp_pc = 16'h0100;
        out_v = 0;
        out_stale = 0;
        exp_iv = 0;
        in_idle = 1;
    endtask

    task automatic wait_iv();
        int n = 0;
        while (!inst_valid && n < 30) begin cycle(); n++; end
        chk("inst_reach", 16'(inst_valid), 16'h1);
    endtask

    task automatic wait_req();
        int n = 0;
        while (!mem_req_valid && n < 30) begin cycle(); n++; end
        chk("req_reach", 16'(mem_req_valid), 16'h1);
    endtask

    task automatic wait_out();
        int n = 0;
        while (!out_v && n < 30) begin cycle(); n++; end
        chk("wait_reach", 16'(out_v), 16'h1);
    endtask

    initial begin
        rdy_pct = 100; irdy_pct = 100; rv_pct = 0; br_pct = 0;
        dly_min = 0; dly_max = 0; tgt_rand = 1; tgt_fix = 16'h0;
        m_pend = 0; m_cnt = 0; m_addr = 16'h0;
        @(negedge clock);
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            cycle();
            if (c % 3 == 0) begin
                chk("tput_valid", 16'(inst_valid), 16'h1);
                chk("tput_pc", inst_pc, 16'(16'h0100 + c / 3 - 1));
            end
            if (c == 3) begin
                chk("wrap_valid", 16'(w_inst_valid), 16'h1);
                chk("wrap_pc", w_inst_pc, 16'hFFFF);
                chk("wrap_data", w_inst_data, 16'h5A5A);
            end
            if (c == 4) begin
                chk("wrap_req_valid", 16'(w_req_valid), 16'h1);
                chk("wrap_req_addr", w_req_addr, 16'h0000);
            end
        end
        irdy_pct = 0;
        wait_iv();
        hp = inst_pc;
        hd = inst_data;
        repeat (10) begin
            cycle();
            chk("hold_valid", 16'(inst_valid), 16'h1);
            chk("hold_pc", inst_pc, hp);
            chk("hold_data", inst_data, hd);
            chk("hold_noreq", 16'(mem_req_valid), 16'h0);
        end
        irdy_pct = 100;
        wait_req();
        chk("after_hold_addr", mem_req_addr, 16'(hp + 16'd1));
        dly_min = 3; dly_max = 3;
        wait_out();
        rv_pct = 100; br_pct = 100; tgt_rand = 0; tgt_fix = 16'h0200;
        cycle();
        rv_pct = 0; tgt_rand = 1;
        wait_req();
        chk("redir_addr", mem_req_addr, 16'h0200);
        wait_iv();
        chk("redir_pc", inst_pc, 16'h0200);
        rv_pct = 100; br_pct = 0; tgt_rand = 0; tgt_fix = 16'h0300;
        rdy_pct = 60; irdy_pct = 70; dly_min = 0; dly_max = 2;
        repeat (40) cycle();
        rv_pct = 15; br_pct = 50; tgt_rand = 1; rdy_pct = 70; irdy_pct = 60; dly_max = 3;
        repeat (3000) cycle();
        rv_pct = 0; irdy_pct = 100; rdy_pct = 100; dly_min = 2; dly_max = 2;
        wait_out();
        do_reset();
        wait_iv();
        chk("post_reset_pc", inst_pc, 16'h0100);
        repeat (5) cycle();
        do_reset();
        rv_pct = 100; br_pct = 100; tgt_rand = 0; tgt_fix = 16'h0400;
        cycle();
        rv_pct = 0; tgt_rand = 1;
        chk("idle_redir_valid", 16'(mem_req_valid), 16'h1);
        chk("idle_redir_addr", mem_req_addr, 16'h0400);
        repeat (10) cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
